// File: rtl/mem_if_rd_req_splitter_pkg.sv
// mem_if_rd_req_splitter_pkg: shared memory-interface field layout and splitter FSM states
package mem_if_rd_req_splitter_pkg;
    localparam int MEM_BEAT_ADDR_WIDTH = 10;
    localparam int MEM_BUF_IDX_WIDTH   = 5;
    localparam int MEM_LENGTH_POS      = 16;
    localparam int MEM_ADDR_WIDTH      = MEM_BEAT_ADDR_WIDTH + MEM_BUF_IDX_WIDTH;
    localparam int AXI4S_DATA_WIDTH    = 32;
    typedef enum logic [1:0] {IDLE, CALC, ISSUE, DRAIN} state_e;
endpackage

// File: rtl/mem_if_rd_req_splitter_outstanding_ctr.sv
// mem_if_outstanding_ctr: saturating up/down count of requests in flight with a below-limit flag
module mem_if_outstanding_ctr #(
    parameter int LIMIT = 8,
    parameter int W     = $clog2(LIMIT + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic dec,
    output logic below,
    output logic dec_taken,
    output logic empty_next
);
    logic [W-1:0] count_q, count_d;
    always_comb begin
        dec_taken  = dec && count_q != '0;
        below      = count_q < W'(LIMIT);
        count_d    = inc && !dec_taken && below ? count_q + 1'b1
                   : !inc && dec_taken ? count_q - 1'b1 : count_q;
        empty_next = count_d == '0;
    end
    always_ff @(posedge clk or negedge reset)
        if (!reset) count_q <= '0;
        else count_q <= count_d;
endmodule

// File: rtl/mem_if_rd_req_splitter.sv
// mem_if_rd_req_splitter: splits one read descriptor into buffer-bounded, size-capped read requests
module mem_if_rd_req_splitter
    import mem_if_rd_req_splitter_pkg::*;
#(
    parameter int BEAT_ADDR_W   = MEM_BEAT_ADDR_WIDTH,
    parameter int BUF_IDX_W     = MEM_BUF_IDX_WIDTH,
    parameter int LEN_POS       = MEM_LENGTH_POS,
    parameter int LEN_W         = 11,
    parameter int TOTAL_LEN_W   = 20,
    parameter int MAX_REQ_BEATS = 256,
    parameter int MAX_OUT       = 8,
    parameter int DATA_W        = AXI4S_DATA_WIDTH
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [BUF_IDX_W+BEAT_ADDR_W-1:0] cmd_addr,
    input  logic [TOTAL_LEN_W-1:0]           cmd_len,
    input  logic                             cmd_valid,
    output logic                             cmd_ready,
    output logic [DATA_W-1:0]                req_axis_tdata,
    output logic                             req_axis_tvalid,
    input  logic                             req_axis_tready,
    input  logic                             mon_tvalid,
    input  logic                             mon_tready,
    input  logic                             mon_tlast,
    input  logic                             mon_tuser,
    output logic                             busy,
    output logic                             done,
    output logic                             err
);
    localparam int ADDR_W    = BUF_IDX_W + BEAT_ADDR_W;
    localparam int BUF_BEATS = 2 ** BEAT_ADDR_W;
    localparam int CW        = TOTAL_LEN_W + 1;

    state_e                 state_q, state_d;
    logic [ADDR_W-1:0]      cur_addr_q, cur_addr_d;
    logic [TOTAL_LEN_W-1:0] remaining_q, remaining_d;
    logic [LEN_W-1:0]       chunk_q, chunk_d;
    logic [DATA_W-1:0]      tdata_q, tdata_d;
    logic                   tvalid_q, tvalid_d, cmd_ready_q, cmd_ready_d;
    logic                   done_q, done_d, err_q, err_d;
    logic [CW-1:0]          room, cap;
    logic                   cmd_fire, req_fire, below, counted, empty_next;

    assign cmd_fire = cmd_valid && cmd_ready_q;
    assign req_fire = tvalid_q && req_axis_tready;

    mem_if_outstanding_ctr #(.LIMIT(MAX_OUT)) u_ctr (
        .clk       (clk),
        .reset     (reset),
        .inc       (req_fire),
        .dec       (mon_tvalid && mon_tready && mon_tlast),
        .below     (below),
        .dec_taken (counted),
        .empty_next(empty_next)
    );

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        chunk_d     = chunk_q;
        tdata_d     = tdata_q;
        tvalid_d    = tvalid_q;
        done_d      = 1'b0;
        room        = CW'(BUF_BEATS) - CW'(cur_addr_q[BEAT_ADDR_W-1:0]);
        cap         = CW'(remaining_q) < CW'(MAX_REQ_BEATS) ? CW'(remaining_q) : CW'(MAX_REQ_BEATS);
        case (state_q)
            IDLE: if (cmd_fire) begin
                cur_addr_d  = cmd_addr;
                remaining_d = cmd_len;
                state_d     = CALC;
            end
            CALC: if (remaining_q == '0) state_d = DRAIN;
            else begin
                chunk_d  = LEN_W'(room < cap ? room : cap);
                tdata_d  = (DATA_W'(chunk_d) << LEN_POS) | DATA_W'(cur_addr_q);
                tvalid_d = below;
                state_d  = ISSUE;
            end
            ISSUE: if (req_fire) begin
                tvalid_d    = 1'b0;
                // one linear add so the buffer index carries and wraps naturally
                cur_addr_d  = cur_addr_q + ADDR_W'(chunk_q);
                remaining_d = remaining_q - TOTAL_LEN_W'(chunk_q);
                state_d     = CALC;
            end else if (!tvalid_q) tvalid_d = below;
            DRAIN: if (empty_next) begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        cmd_ready_d = state_d == IDLE;
        err_d       = cmd_fire ? 1'b0 : counted && !mon_tuser ? 1'b1 : err_q;
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state_q     <= IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            chunk_q     <= '0;
            tdata_q     <= '0;
            tvalid_q    <= 1'b0;
            cmd_ready_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            chunk_q     <= chunk_d;
            tdata_q     <= tdata_d;
            tvalid_q    <= tvalid_d;
            cmd_ready_q <= cmd_ready_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end

    assign cmd_ready       = cmd_ready_q;
    assign req_axis_tdata  = tdata_q;
    assign req_axis_tvalid = tvalid_q;
    assign busy            = state_q != IDLE;
    assign done            = done_q;
    assign err             = err_q;
endmodule
